// File: rtl/intr_pkg.sv
// Shared definitions for the I/O interrupt controller: FSM states, default vectors
// and source count.
package intr_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [9:0] SUB1 = 10'd984;
  localparam logic [9:0] SUB2 = 10'd994;
  localparam logic [9:0] SUB3 = 10'd1004;
  localparam logic [9:0] SUB4 = 10'd1014;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins (iport1 highest priority).
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [1:0]         idx_o
);

  // Scanning downward lets the lowest set bit make the final assignment.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 2'(i);
      end
    end
  end

endmodule

// File: rtl/intr_controller.sv
// Interrupt controller: rising-edge request capture, masking, fixed-priority selection,
// one-cycle jump strobe, non-nested service with an optional watchdog abort.
module intr_controller #(
  parameter logic [9:0]  SUB1    = intr_pkg::SUB1,
  parameter logic [9:0]  SUB2    = intr_pkg::SUB2,
  parameter logic [9:0]  SUB3    = intr_pkg::SUB3,
  parameter logic [9:0]  SUB4    = intr_pkg::SUB4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iport1,
  input  logic       iport2,
  input  logic       iport3,
  input  logic       iport4,
  input  logic       ien,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       fin,
  output logic [9:0] dir,
  output logic       s_interrup,
  output logic       busy,
  output logic [1:0] src,
  output logic [3:0] pend,
  output logic       tmo_err,
  output logic [1:0] dbg_state
);

  import intr_pkg::*;

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  state_e          state_q;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      mask_q;
  logic [3:0]      prev_q;
  logic [9:0]      dir_q;
  logic [1:0]      src_q;
  logic            strobe_q;
  logic            busy_q;
  logic            tmo_q;
  logic [WD_W-1:0] wd_q;

  logic [3:0] req_now, edge_w, elig, clr;
  logic       win_valid, take;
  logic [1:0] win_idx;
  logic [9:0] vec_sel;

  assign req_now = {iport4, iport3, iport2, iport1};
  assign edge_w  = req_now & ~prev_q;
  assign elig    = pend_q & mask_q & {4{ien}};

  intr_prio_enc u_prio_enc (
    .req_i   (elig),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  assign take = (state_q == IDLE) && win_valid;
  assign clr  = take ? (4'b0001 << win_idx) : 4'b0000;
  // A fresh edge on the winning source re-arms it, so set beats clear.
  assign pend_d = (pend_q & ~clr) | edge_w;

  always_comb begin
    case (win_idx)
      2'd0:    vec_sel = SUB1;
      2'd1:    vec_sel = SUB2;
      2'd2:    vec_sel = SUB3;
      default: vec_sel = SUB4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pend_q   <= 4'h0;
      mask_q   <= 4'hF;
      prev_q   <= 4'h0;
      dir_q    <= 10'd0;
      src_q    <= 2'd0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      prev_q   <= req_now;
      pend_q   <= pend_d;
      strobe_q <= 1'b0;
      if (mask_we) begin
        mask_q <= mask_in;
        tmo_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q  <= TAKE;
            src_q    <= win_idx;
            dir_q    <= vec_sel;
            strobe_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        TAKE: begin
          state_q <= SERVICE;
          wd_q    <= '0;
        end
        SERVICE: begin
          if (fin) begin
            state_q <= IDLE;
            dir_q   <= 10'd0;
            src_q   <= 2'd0;
            busy_q  <= 1'b0;
          end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
            // Abort wins over a same-cycle mask write so the error is never lost.
            state_q <= IDLE;
            dir_q   <= 10'd0;
            src_q   <= 2'd0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dir        = dir_q;
  assign s_interrup = strobe_q;
  assign busy       = busy_q;
  assign src        = src_q;
  assign pend       = pend_q;
  assign tmo_err    = tmo_q;
  assign dbg_state  = state_q;

endmodule
